// File: rtl/msx_bus_pkg.sv
// Shared MSX bus definitions: wait-generator state encoding and default wait counts.
// Used by the Z80 wait-state generator and its counter.
package msx_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } wait_state_t;

   // Standard MSX timing: one wait on opcode fetch, none on I/O.
   localparam int MSX_M1_WAITS     = 1;
   localparam int MSX_VDP_IO_WAITS = 0;
   localparam int MSX_CNT_W        = 4;

   // True when no Z80 cycle strobe is asserted.
   function automatic logic bus_quiet(input logic m1_n, input logic mreq_n, input logic iorq_n);
      return m1_n & mreq_n & iorq_n;
   endfunction

endpackage

// File: rtl/msx_wait_counter.sv
// Loadable down-counter that tracks the remaining wait clocks of one bus cycle.
// It never wraps: a decrement request at zero leaves it at zero.
module msx_wait_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/msx_wait_gen.sv
// Z80 /WAIT generator for the MSX bus: holds /WAIT low for a fixed number of clocks
// at the start of each opcode-fetch or I/O cycle, then idles until the strobes release.
module msx_wait_gen
   import msx_bus_pkg::*;
#(
   parameter int M1_WAITS = MSX_M1_WAITS,
   parameter int IO_WAITS = MSX_VDP_IO_WAITS,
   parameter int CNT_W    = MSX_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic m1_n,
   input  logic mreq_n,
   input  logic iorq_n,
   input  logic wait_en,
   output logic wait_n,
   output logic busy
);

   // The counter is loaded with N-1 because the load edge itself starts the first wait clock.
   localparam logic [CNT_W-1:0] M1_LOAD = (M1_WAITS > 0) ? CNT_W'(M1_WAITS - 1) : '0;
   localparam logic [CNT_W-1:0] IO_LOAD = (IO_WAITS > 0) ? CNT_W'(IO_WAITS - 1) : '0;
   localparam logic M1_HAS_WAIT = (M1_WAITS > 0);
   localparam logic IO_HAS_WAIT = (IO_WAITS > 0);

   wait_state_t      state_reg;
   wait_state_t      state_next;
   logic             wait_n_reg;
   logic             wait_n_next;

   logic             m1_req;
   logic             io_req;
   logic             intack;
   logic             any_req;
   logic             quiet;
   logic             m1_wait;
   logic             io_wait;

   logic             cnt_clr;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;

   // Request decode; an intack looks like I/O but must never get extra waits.
   always_comb begin
      m1_req  = !m1_n & !mreq_n;
      io_req  = !iorq_n & m1_n;
      intack  = !m1_n & !iorq_n;
      any_req = m1_req | io_req | intack;
      quiet   = bus_quiet(m1_n, mreq_n, iorq_n);
      m1_wait = m1_req & wait_en & M1_HAS_WAIT;
      io_wait = io_req & !m1_req & wait_en & IO_HAS_WAIT;
   end

   msx_wait_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         wait_n_reg <= 1'b1;
      end else begin
         state_reg  <= state_next;
         wait_n_reg <= wait_n_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (m1_wait || io_wait) begin
               state_next = ST_WAIT;
            end else if (any_req) begin
               state_next = ST_HOLD;
            end
         end
         ST_WAIT: begin
            if (quiet) begin
               state_next = ST_IDLE;
            end else if (cnt_zero) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (quiet) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // A cycle that aborts mid-wait clears the counter so nothing carries into the next cycle.
   always_comb begin
      wait_n_next  = 1'b1;
      cnt_clr      = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (m1_wait) begin
               cnt_load     = 1'b1;
               cnt_load_val = M1_LOAD;
               wait_n_next  = 1'b0;
            end else if (io_wait) begin
               cnt_load     = 1'b1;
               cnt_load_val = IO_LOAD;
               wait_n_next  = 1'b0;
            end
         end
         ST_WAIT: begin
            if (quiet) begin
               cnt_clr = 1'b1;
            end else if (!cnt_zero) begin
               cnt_dec     = 1'b1;
               wait_n_next = 1'b0;
            end
         end
         ST_HOLD: begin
            wait_n_next = 1'b1;
         end
         default: begin
            cnt_clr = 1'b1;
         end
      endcase
   end

   assign wait_n = wait_n_reg;
   assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_msx_wait_gen.sv
// Bench for msx_wait_gen: three parameterisations share one bus, each checked against
// a per-bus-cycle wait budget model, plus a vector table and corner-case sequences.
module tb_msx_wait_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       m1_n;
   logic       mreq_n;
   logic       iorq_n;
   logic       wait_en;
   logic [2:0] wait_n_v;
   logic [2:0] busy_v;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   msx_wait_gen dut_a (
      .clk (clk), .rst_n (rst_n), .m1_n (m1_n), .mreq_n (mreq_n), .iorq_n (iorq_n),
      .wait_en (wait_en), .wait_n (wait_n_v[0]), .busy (busy_v[0])
   );

   msx_wait_gen #(.M1_WAITS (5), .IO_WAITS (3), .CNT_W (4)) dut_b (
      .clk (clk), .rst_n (rst_n), .m1_n (m1_n), .mreq_n (mreq_n), .iorq_n (iorq_n),
      .wait_en (wait_en), .wait_n (wait_n_v[1]), .busy (busy_v[1])
   );

   msx_wait_gen #(.M1_WAITS (4), .IO_WAITS (0), .CNT_W (4)) dut_c (
      .clk (clk), .rst_n (rst_n), .m1_n (m1_n), .mreq_n (mreq_n), .iorq_n (iorq_n),
      .wait_en (wait_en), .wait_n (wait_n_v[2]), .busy (busy_v[2])
   );

   // Model: a bus cycle starts on the first sampled request and is granted a wait
   // budget; /WAIT is low while budget remains, the cycle ends when the bus goes quiet.
   int m1w [3] = '{1, 5, 4};
   int iow [3] = '{0, 3, 0};
   int left [3];
   bit in_cyc [3];

   wire req_m1    = !m1_n && !mreq_n;
   wire req_io    = !iorq_n && m1_n;
   wire req_ia    = !m1_n && !iorq_n;
   wire bus_quiet = m1_n && mreq_n && iorq_n;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            in_cyc[i] <= 1'b0;
            left[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!in_cyc[i]) begin
               if (req_m1 || req_io || req_ia) begin
                  in_cyc[i] <= 1'b1;
                  if (req_m1)      left[i] <= wait_en ? m1w[i] : 0;
                  else if (req_io) left[i] <= wait_en ? iow[i] : 0;
                  else             left[i] <= 0;
               end
            end else if (bus_quiet) begin
               in_cyc[i] <= 1'b0;
               left[i]   <= 0;
            end else if (left[i] > 0) begin
               left[i] <= left[i] - 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_models(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s.wait_n[%0d]", tag, i), wait_n_v[i], (left[i] == 0) ? 1'b1 : 1'b0);
         check($sformatf("%s.busy[%0d]", tag, i), busy_v[i], in_cyc[i] ? 1'b1 : 1'b0);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic m1, input logic mreq, input logic iorq, input logic en);
      m1_n    = m1;
      mreq_n  = mreq;
      iorq_n  = iorq;
      wait_en = en;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic count_lows(input string tag, input logic m1, input logic mreq, input logic iorq,
                             input int n, input int idx, output int lows, output int runs);
      logic prev;
      prev = 1'b1;
      lows = 0;
      runs = 0;
      for (int k = 0; k < n; k++) begin
         step(m1, mreq, iorq, 1'b1);
         check_models(tag);
         if (wait_n_v[idx] == 1'b0) begin
            lows++;
            if (prev) runs++;
         end
         prev = wait_n_v[idx];
      end
   endtask

   typedef struct {
      logic m1_n;
      logic mreq_n;
      logic iorq_n;
      logic en;
      logic exp_wait_n;
      logic exp_busy;
   } vec_t;

   vec_t vecs [24];

   initial begin
      int lows;
      int runs;
      int kind;

      // Default-parameter vectors (M1 one wait, I/O no wait), from IDLE.
      vecs[0]  = '{1, 1, 1, 1, 1, 0};
      vecs[1]  = '{0, 0, 1, 1, 0, 1};
      vecs[2]  = '{0, 0, 1, 1, 1, 1};
      vecs[3]  = '{0, 0, 1, 1, 1, 1};
      vecs[4]  = '{0, 0, 1, 1, 1, 1};
      vecs[5]  = '{1, 1, 1, 1, 1, 0};
      vecs[6]  = '{1, 1, 0, 1, 1, 1};
      vecs[7]  = '{1, 1, 0, 1, 1, 1};
      vecs[8]  = '{1, 1, 1, 1, 1, 0};
      vecs[9]  = '{0, 1, 0, 1, 1, 1};
      vecs[10] = '{1, 1, 1, 1, 1, 0};
      vecs[11] = '{0, 0, 1, 0, 1, 1};
      vecs[12] = '{0, 0, 1, 1, 1, 1};
      vecs[13] = '{1, 1, 1, 1, 1, 0};
      vecs[14] = '{0, 0, 1, 1, 0, 1};
      vecs[15] = '{1, 1, 1, 1, 1, 0};
      vecs[16] = '{0, 0, 1, 1, 0, 1};
      vecs[17] = '{0, 0, 1, 1, 1, 1};
      vecs[18] = '{1, 0, 1, 1, 1, 1};
      vecs[19] = '{1, 1, 1, 1, 1, 0};
      vecs[20] = '{1, 0, 1, 1, 1, 0};
      vecs[21] = '{1, 1, 1, 1, 1, 0};
      vecs[22] = '{0, 0, 0, 1, 0, 1};
      vecs[23] = '{1, 1, 1, 1, 1, 0};

      // Reset held with a fetch pending on the bus.
      rst_n   = 1'b0;
      m1_n    = 1'b0;
      mreq_n  = 1'b0;
      iorq_n  = 1'b1;
      wait_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.wait_n", wait_n_v[0], 1'b1);
      check("reset.busy", busy_v[0], 1'b0);
      check_models("reset");
      $display("txn reset held: wait_n=%b busy=%b", wait_n_v[0], busy_v[0]);

      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release.wait_n", wait_n_v[0], 1'b0);
      check_models("release");
      $display("txn reset released: wait_n=%b", wait_n_v[0]);
      step(1, 1, 1, 1);
      check_models("release_idle");

      for (int v = 0; v < 24; v++) begin
         step(vecs[v].m1_n, vecs[v].mreq_n, vecs[v].iorq_n, vecs[v].en);
         check($sformatf("vec%0d.wait_n", v), wait_n_v[0], vecs[v].exp_wait_n);
         check($sformatf("vec%0d.busy", v), busy_v[0], vecs[v].exp_busy);
         check_models($sformatf("vec%0d", v));
         $display("txn vec%0d: m1_n=%b mreq_n=%b iorq_n=%b en=%b -> wait_n=%b busy=%b",
                  v, vecs[v].m1_n, vecs[v].mreq_n, vecs[v].iorq_n, vecs[v].en,
                  wait_n_v[0], busy_v[0]);
      end

      // I/O cycle with three waits, then an intack that must get none.
      count_lows("io3", 1, 1, 0, 6, 1, lows, runs);
      check("io3.lows", (lows == 3), 1'b1);
      check("io3.runs", (runs == 1), 1'b1);
      $display("txn io cycle: lows=%0d runs=%0d", lows, runs);
      step(1, 1, 1, 1);
      check_models("io3_end");
      count_lows("intack", 0, 1, 0, 4, 1, lows, runs);
      check("intack.lows", (lows == 0), 1'b1);
      $display("txn intack: lows=%0d", lows);
      step(1, 1, 1, 1);
      check_models("intack_end");

      // Abort after two of five waits, then a full fetch right behind it.
      step(0, 0, 1, 1);
      check("abort.w1", wait_n_v[1], 1'b0);
      step(0, 0, 1, 1);
      check("abort.w2", wait_n_v[1], 1'b0);
      step(1, 1, 1, 1);
      check("abort.wait_n", wait_n_v[1], 1'b1);
      check("abort.busy", busy_v[1], 1'b0);
      check_models("abort");
      count_lows("refetch", 0, 0, 1, 7, 1, lows, runs);
      check("refetch.lows", (lows == 5), 1'b1);
      check("refetch.runs", (runs == 1), 1'b1);
      $display("txn abort+refetch: lows=%0d runs=%0d", lows, runs);
      step(1, 1, 1, 1);
      check_models("refetch_end");

      // Asynchronous reset between edges in the middle of a four-wait fetch.
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      check("arst.pre", wait_n_v[2], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst.wait_n", wait_n_v[2], 1'b1);
      check("arst.busy", busy_v[2], 1'b0);
      check_models("arst");
      $display("txn async reset mid-wait: wait_n=%b busy=%b", wait_n_v[2], busy_v[2]);
      @(negedge clk);
      m1_n   = 1'b1;
      mreq_n = 1'b1;
      iorq_n = 1'b1;
      rst_n  = 1'b1;
      step(1, 1, 1, 1);
      check_models("arst_end");

      // Random bus traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            3, 4:    step(1, 1, 1, ($urandom_range(0, 3) != 0));
            5:       step(0, 0, 1, ($urandom_range(0, 3) != 0));
            6:       step(1, 1, 0, ($urandom_range(0, 3) != 0));
            7:       step(0, 1, 0, ($urandom_range(0, 3) != 0));
            8:       step(1, 0, 1, ($urandom_range(0, 3) != 0));
            9:       step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            default: step(m1_n, mreq_n, iorq_n, ($urandom_range(0, 3) != 0));
         endcase
         check_models($sformatf("rand%0d", c));
      end
      $display("txn random: 2000 cycles applied");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
